// File: rtl/datapath_legv8_mc.sv
// Multi-cycle LEGv8 datapath: register file, ALU, status flags, registered bus select
// and a req/ack data-memory port with an optional wait timeout and sticky error flag.
module datapath_legv8_mc #(
    parameter int WIDTH   = 64,
    parameter int REGS    = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15,
    localparam int RW     = $clog2(REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [RW-1:0]     DA,
    input  logic [RW-1:0]     SA,
    input  logic [RW-1:0]     SB,
    input  logic [3:0]        FS,
    input  logic              Asel,
    input  logic              Bsel,
    input  logic [1:0]        data_sel,
    input  logic              WR,
    input  logic              WM,
    input  logic              SL,
    input  logic [WIDTH-1:0]  constant,
    input  logic [WIDTH-1:0]  pc4,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  data_bus,
    output logic [4:0]        status,
    output logic              mem_err,
    output logic              state_dbg
);
    typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Handshake: a control word is taken on a rising edge where cw_valid && cw_ready.
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [REGS];
    logic [WIDTH-1:0]  regs_d [REGS];
    logic [TW-1:0]     wait_q, wait_d;
    logic [RW-1:0]     lat_da_q, lat_da_d;
    logic              lat_wr_q, lat_wr_d, lat_sl_q, lat_sl_d, lat_ld_q, lat_ld_d;
    logic [WIDTH-1:0]  lat_bus_q, lat_bus_d;
    logic [3:0]        lat_flags_q, lat_flags_d, flags_q, flags_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_err_q, mem_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d, data_bus_q, data_bus_d;

    logic [WIDTH-1:0]  rd_a, rd_b, op_a, op_b, op_bx, alu_res, bus, wb_val, rf_wdata;
    logic [WIDTH:0]    sum_ext;
    logic [5:0]        shamt;
    logic              alu_c, alu_v, rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [3:0]        alu_flags;

    // The top register is XZR: it always reads as zero.
    assign rd_a = (SA >= RW'(REGS - 1)) ? '0 : regs_q[SA];
    assign rd_b = (SB >= RW'(REGS - 1)) ? '0 : regs_q[SB];

    always_comb begin
        op_a    = Asel ? constant : rd_a;
        op_b    = Bsel ? constant : rd_b;
        op_bx   = FS[0] ? ~op_b : op_b;
        sum_ext = {1'b0, op_a} + {1'b0, op_bx} + {{WIDTH{1'b0}}, FS[0]};
        shamt   = op_bx[5:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (FS[3:1])
            3'b000: alu_res = op_a & op_bx;
            3'b001: alu_res = op_a | op_bx;
            3'b010: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_bx[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'b011: alu_res = op_a ^ op_bx;
            3'b100: alu_res = (int'(shamt) >= WIDTH) ? '0 : (op_a << shamt);
            3'b101: alu_res = (int'(shamt) >= WIDTH) ? '0 : (op_a >> shamt);
            3'b110: alu_res = op_a;
            default: alu_res = op_bx;
        endcase
        alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
        case (data_sel)
            2'b00:   bus = alu_res;
            2'b01:   bus = mem_rdata;
            2'b10:   bus = pc4;
            default: bus = constant;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        lat_da_d    = lat_da_q;
        lat_wr_d    = lat_wr_q;
        lat_sl_d    = lat_sl_q;
        lat_ld_d    = lat_ld_q;
        lat_bus_d   = lat_bus_q;
        lat_flags_d = lat_flags_q;
        flags_d     = flags_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        data_bus_d  = data_bus_q;
        rf_we       = 1'b0;
        rf_waddr    = DA;
        rf_wdata    = bus;
        wb_val      = lat_ld_q ? mem_rdata : lat_bus_q;
        case (state_q)
            S_IDLE: begin
                if (cw_valid) begin
                    if (data_sel == 2'b01 || WM) begin
                        lat_da_d    = DA;
                        lat_wr_d    = WR;
                        lat_sl_d    = SL;
                        lat_ld_d    = (data_sel == 2'b01);
                        lat_bus_d   = bus;
                        lat_flags_d = alu_flags;
                        mem_req_d   = 1'b1;
                        mem_we_d    = WM;
                        mem_addr_d  = alu_res[ADDR_W-1:0];
                        mem_wdata_d = rd_b;
                        wait_d      = '0;
                        state_d     = S_MEM;
                    end else begin
                        rf_we      = WR;
                        data_bus_d = bus;
                        if (SL) flags_d = alu_flags;
                    end
                end
            end
            default: begin
                // An ack on the same edge as the timeout still completes normally.
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    rf_we      = lat_wr_q;
                    rf_waddr   = lat_da_q;
                    rf_wdata   = wb_val;
                    data_bus_d = wb_val;
                    if (lat_sl_q) flags_d = lat_flags_q;
                    state_d    = S_IDLE;
                end else if (TIMEOUT > 0 && wait_q == TW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
        endcase
        for (int i = 0; i < REGS; i++) regs_d[i] = regs_q[i];
        if (rf_we && rf_waddr < RW'(REGS - 1)) regs_d[rf_waddr] = rf_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
            wait_q      <= '0;
            lat_da_q    <= '0;
            lat_wr_q    <= 1'b0;
            lat_sl_q    <= 1'b0;
            lat_ld_q    <= 1'b0;
            lat_bus_q   <= '0;
            lat_flags_q <= '0;
            flags_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            data_bus_q  <= '0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < REGS; i++) regs_q[i] <= regs_d[i];
            wait_q      <= wait_d;
            lat_da_q    <= lat_da_d;
            lat_wr_q    <= lat_wr_d;
            lat_sl_q    <= lat_sl_d;
            lat_ld_q    <= lat_ld_d;
            lat_bus_q   <= lat_bus_d;
            lat_flags_q <= lat_flags_d;
            flags_q     <= flags_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            data_bus_q  <= data_bus_d;
        end
    end

    assign cw_ready  = (state_q == S_IDLE);
    assign state_dbg = state_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign data_bus  = data_bus_q;
    assign status    = {flags_q, alu_flags[2]};
    assign mem_err   = mem_err_q;
endmodule

// File: tb/tb_datapath_legv8_mc.sv
// Directed bench for datapath_legv8_mc: ALU ops, flags, loads, stores, timeout, XZR, reset.
module tb_datapath_legv8_mc;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic [4:0]  DA = '0, SA = '0, SB = '0;
    logic [3:0]  FS = '0;
    logic        Asel = 1'b0, Bsel = 1'b0;
    logic [1:0]  data_sel = '0;
    logic        WR = 1'b0, WM = 1'b0, SL = 1'b0;
    logic [63:0] constant = '0, pc4 = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata = '0, data_bus;
    logic [4:0]  status;
    logic        mem_err, state_dbg;

    int checks = 0;
    int failures = 0;
    int lows;
    logic [63:0] rv;

    datapath_legv8_mc dut (
        .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .DA(DA), .SA(SA), .SB(SB), .FS(FS), .Asel(Asel), .Bsel(Bsel),
        .data_sel(data_sel), .WR(WR), .WM(WM), .SL(SL), .constant(constant), .pc4(pc4),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_bus(data_bus), .status(status),
        .mem_err(mem_err), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cw(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                      input logic [3:0] fs, input logic asel, input logic bsel,
                      input logic [1:0] dsel, input logic wr, input logic wm, input logic sl,
                      input logic [63:0] k);
        DA = da; SA = sa; SB = sb; FS = fs; Asel = asel; Bsel = bsel;
        data_sel = dsel; WR = wr; WM = wm; SL = sl; constant = k; cw_valid = 1'b1;
    endtask

    task automatic idle();
        cw_valid = 1'b0; WR = 1'b0; WM = 1'b0; SL = 1'b0;
    endtask

    // Observe a register through the bus: pass A, no write-back, no flag load.
    task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
        cw(5'd0, r, 5'd0, 4'b1100, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        v = data_bus;
    endtask

    initial begin
        #3;
        check("rst_ready", cw_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_bus", data_bus, 0);
        check("rst_flags", status[4:1], 0);
        check("rst_err", mem_err, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        cw(5'd1, 5'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 64'd5); tick();
        check("ld_r1_bus", data_bus, 64'd5);
        cw(5'd2, 5'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 64'd3); tick();

        cw(5'd3, 5'd1, 5'd2, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 64'd0); tick();
        check("add_bus", data_bus, 64'd8);
        check("add_status", status, 5'b00000);
        check("add_ready", cw_ready, 1);
        idle();
        read_reg(5'd3, rv); check("r3", rv, 64'd8);

        cw(5'd4, 5'd2, 5'd1, 4'b0101, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 64'd0); tick();
        check("sub_bus", data_bus, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_status", status, 5'b10000);
        idle();
        read_reg(5'd4, rv); check("r4", rv, 64'hFFFF_FFFF_FFFF_FFFE);

        cw(5'd31, 5'd1, 5'd1, 4'b0101, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 64'd0); tick();
        check("sub_zero_status", status, 5'b01101);
        cw(5'd0, 5'd0, 5'd1, 4'b0100, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF); tick();
        check("ovf_bus", data_bus, 64'h8000_0000_0000_0004);
        check("ovf_status", status[4:1], 4'b1001);
        cw(5'd0, 5'd1, 5'd2, 4'b0110, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 64'd0); tick();
        check("xor_bus", data_bus, 64'd6);
        check("xor_flags", status[4:1], 4'b0000);
        cw(5'd0, 5'd1, 5'd2, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0); tick();
        check("bic_bus", data_bus, 64'd4);
        cw(5'd0, 5'd1, 5'd2, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0); tick();
        check("or_bus", data_bus, 64'd7);
        cw(5'd0, 5'd1, 5'd0, 4'b1000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 64'd4); tick();
        check("lsl_bus", data_bus, 64'h50);
        cw(5'd0, 5'd3, 5'd2, 4'b1010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0); tick();
        check("lsr_bus", data_bus, 64'd1);
        pc4 = 64'h1004;
        cw(5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 64'd0); tick();
        check("pc4_bus", data_bus, 64'h1004);

        // Load: address 16 + R1 = 0x15, three idle MEM cycles then ack.
        cw(5'd5, 5'd1, 5'd0, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 64'd16); tick();
        idle();
        check("ld_req", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, 8'h15);
        lows = (cw_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cw_ready == 1'b0) lows++;
        end
        mem_ack = 1'b1; mem_rdata = 64'hABCD; tick(); mem_ack = 1'b0;
        check("ld_lows", lows, 4);
        check("ld_ready_after", cw_ready, 1);
        check("ld_req_drop", mem_req, 0);
        check("ld_bus", data_bus, 64'hABCD);
        read_reg(5'd5, rv); check("r5", rv, 64'hABCD);

        // Store R6 with write-back of the latched ALU address into R7.
        cw(5'd6, 5'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 64'h55); tick();
        cw(5'd7, 5'd1, 5'd6, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 64'h20); tick();
        idle();
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 64'h55);
        check("st_addr", mem_addr, 8'h25);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("st_req_drop", mem_req, 0);
        check("st_we_drop", mem_we, 0);
        check("st_bus", data_bus, 64'h25);
        read_reg(5'd6, rv); check("r6_kept", rv, 64'h55);
        read_reg(5'd7, rv); check("r7_wb", rv, 64'h25);

        // Ack arriving on the 15th MEM cycle completes normally.
        cw(5'd8, 5'd1, 5'd0, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 64'd0); tick();
        idle();
        for (int i = 0; i < 14; i++) tick();
        check("late_req_held", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 64'h1234; tick(); mem_ack = 1'b0;
        check("late_err", mem_err, 0);
        check("late_ready", cw_ready, 1);
        read_reg(5'd8, rv); check("r8", rv, 64'h1234);

        // No ack: abort after 15 MEM cycles, R3 untouched.
        cw(5'd3, 5'd1, 5'd0, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 64'd0); tick();
        idle();
        for (int i = 0; i < 14; i++) tick();
        check("to_req_14", mem_req, 1);
        tick();
        check("to_req_15", mem_req, 0);
        check("to_err", mem_err, 1);
        check("to_ready", cw_ready, 1);
        read_reg(5'd3, rv); check("r3_kept", rv, 64'd8);
        check("to_err_sticky", mem_err, 1);

        cw(5'd31, 5'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 64'd7); tick();
        idle();
        read_reg(5'd31, rv); check("xzr", rv, 64'd0);

        // Reset in the middle of a memory wait.
        cw(5'd9, 5'd1, 5'd0, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 64'd0); tick();
        idle();
        tick();
        check("pre_rst_req", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_ready", cw_ready, 1);
        check("mid_rst_err", mem_err, 0);
        check("mid_rst_bus", data_bus, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        read_reg(5'd1, rv); check("r1_cleared", rv, 64'd0);
        read_reg(5'd5, rv); check("r5_cleared", rv, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_legv8_mc.md
Name: datapath_legv8_mc

Overview:
Parametrised multi-cycle LEGv8 datapath: register file, ALU, status register and an internal data-bus mux, generalised in data width, register count and memory address width. Replaces the tri-state data bus with a registered source select, and replaces the fixed-latency RAM with a req/ack memory port. Adds a memory timeout with a sticky error flag. Sits between the control unit, which issues one control word per cw_valid/cw_ready handshake, and an external data memory; PC+4 is supplied by the program counter.

Parameters:
WIDTH, 64, data/register width in bits (>=8)
REGS, 32, register count; register REGS-1 is XZR
ADDR_W, 8, memory address width; mem_addr = ALU result[ADDR_W-1:0]
TIMEOUT, 15, cycles to wait for mem_ack before abort; 0 = wait forever

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
cw_valid  in  1  control word present
cw_ready  out  1  datapath can accept a control word
DA, SA, SB  in  clog2(REGS) each  dest/source A/source B register
FS  in  4  FS[3:1] op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR, 110 pass A, 111 pass B; FS[0] inverts B and is carry-in
Asel, Bsel  in  1 each  1 = constant replaces A / B operand
data_sel  in  2  bus source: 00 ALU, 01 memory read, 10 pc4, 11 constant
WR, WM, SL  in  1 each  register write, memory write, status load
constant  in  WIDTH  immediate
pc4  in  WIDTH  PC+4 from program counter
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  write request
mem_addr  out  ADDR_W  address
mem_wdata  out  WIDTH  store data (register SB)
mem_ack  in  1  memory completion
mem_rdata  in  WIDTH  load data, valid with mem_ack
data_bus  out  WIDTH  selected bus value of last completed word
status  out  5  {N,Z,C,V} registered flags in [4:1]; [0] live zero of current ALU result
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: all registers 0, state IDLE, cw_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_bus=0, status[4:1]=0, mem_err=0. Takes effect immediately, including mid-MEM (mem_req drops asynchronously).
- Register file: two combinational reads, one synchronous write. Reads of REGS-1 return 0; writes to REGS-1 are ignored. Read of a register being written the same cycle returns the old value.
- ALU: A = Asel ? constant : R[SA]; B' = Bsel ? constant : R[SB]; Bx = FS[0] ? ~B' : B'. ADD = A + Bx + FS[0], WIDTH bits. C is the carry out; V is signed overflow. LSL/LSR shift A by Bx[5:0] (shifts >= WIDTH yield 0). N = result MSB; Z = result==0. C=V=0 for non-ADD ops.
- States: IDLE, MEM.
- IDLE, accept (cw_valid & cw_ready) with data_sel!=01 and WM=0: single-cycle completion at that edge.
  - If WR: R[DA] <= bus.
  - If SL: flags <= ALU flags.
  - data_bus <= bus.
  - Stay IDLE.
- IDLE, accept with data_sel==01 or WM=1: latch DA, WR, SL, data_sel, ALU result and flags, and R[SB].
  - mem_req=1, mem_we=WM, mem_addr, mem_wdata registered.
  - Go to MEM; cw_ready=0.
- MEM: mem_ack is sampled only here.
  - On ack: drop mem_req and mem_we.
  - If data_sel==01 & WR: R[DA] <= mem_rdata, and data_bus <= mem_rdata. Otherwise the write-back and data_bus source is the latched data_sel.
  - If SL: flags <= latched flags.
  - Return to IDLE; cw_ready=1 the next cycle.
- Timeout (TIMEOUT>0): a wait counter counts cycles in MEM with no ack. When it reaches TIMEOUT: abort, mem_req=0, no register or flag write, mem_err<=1, return to IDLE. Ack arriving on the same cycle as the timeout wins (normal completion).
- mem_err is cleared only by reset. It does not block further control words.
- cw_valid while cw_ready=0 is ignored; the control unit must hold the word.
- status[0] is combinational from the current A/B/FS inputs, for CBZ decisions.

Test Plan:
- R1=5, R2=3 preloaded via data_sel=11; ADD DA=3, SA=1, SB=2, WR=1, SL=1 -> R3=8, status[4:1]=0000, cw_ready stays 1.
- SUB (FS=0101) R2-R1 with SL -> result 0xFFFF_FFFF_FFFF_FFFE; N=1, Z=0, C=0, V=0.
- Load: Bsel=1, constant=16, data_sel=01, WR=1; ack after 3 cycles with rdata=0xABCD -> mem_addr=16+R[SA], cw_ready low for 4 cycles, R[DA]=0xABCD.
- Store: WM=1, R[SB]=0x55 -> mem_req=1, mem_we=1, mem_wdata=0x55; no register change; ack completes in next cycle.
- No ack, TIMEOUT=15 -> abort after 15 MEM cycles, mem_err=1, R[DA] unchanged. Repeat with ack on cycle 15 -> normal completion, mem_err=0.
- Write 7 to R31 -> reads 0. Assert reset during MEM -> mem_req=0 immediately, all registers 0, cw_ready=1 after release.
